prio_encoder_8x3_hs: RTL and testbench

- Sequential counterpart to the team's 3-to-8 one-hot decoder.
- Latches request pulses on 8 lines into a pending register and encodes the winning line to a 3-bit index.
- Presents each index on a valid/ready output port, one per transfer, and retires the served request.
- Feeds the decoder or any index-consuming block downstream; serves interrupt-style request aggregation in lab designs.

---
 rtl/prio_enc_pkg.sv | 33 +++
 rtl/prio_encoder_8x3_hs_find.sv | 35 +++
 rtl/prio_encoder_8x3_hs.sv | 112 +++++++++++
 tb/tb_prio_encoder_8x3_hs.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the prio_encoder_8x3_hs slice.
// The index width is fixed here; the top-level W parameter defaults to it.
package prio_enc_pkg;

    localparam int W = 3;
    localparam int N = 1 << W;

    // Serving state: IDLE has nothing on the output port, HOLD presents an index.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Result of a bit search: whether any bit was set, and where.
    typedef struct packed {
        logic         found;
        logic [W-1:0] idx;
    } hit_t;

    // Highest-set-bit encode; idx is 0 when no bit is set.
    function automatic hit_t highest_set(input logic [N-1:0] vec);
        hit_t hit;
        hit = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                hit.found = 1'b1;
                hit.idx   = W'(i);
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/prio_encoder_8x3_hs_find.sv
// prio_find: combinational find-first-set searching upward from a start
// offset and wrapping from bit N-1 to bit 0.
module prio_find #(
    parameter int W = prio_enc_pkg::W
) (
    input  logic [(1<<W)-1:0] vec,
    input  logic [W-1:0]      start,
    output logic [W-1:0]      idx,
    output logic              found
);
    localparam int N = 1 << W;

    logic [N-1:0]       rot;
    logic [N-1:0]       rev;
    prio_enc_pkg::hit_t hit;

    // Rotate so the start bit sits at position 0, then the lowest set bit of
    // the rotated vector is the first hit; reversing turns that into a
    // highest-set search.
    always_comb begin
        rot = '0;
        rev = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = vec[W'(i) + start];
        end
        for (int i = 0; i < N; i++) begin
            rev[i] = rot[N-1-i];
        end
        hit   = prio_enc_pkg::highest_set(rev);
        found = hit.found;
        // W-bit arithmetic wraps the index back into range.
        idx   = W'(N-1) - hit.idx + start;
    end

endmodule

// File: rtl/prio_encoder_8x3_hs.sv
// prio_encoder_8x3_hs: latches request pulses into a pending register and
// serves one encoded index per valid/ready transfer.
// Build option: define PRIO_ENC_ROUND_ROBIN_EN for rotating priority
// (starvation-free); otherwise the highest pending index always wins.
module prio_encoder_8x3_hs #(
    parameter int W = prio_enc_pkg::W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [(1<<W)-1:0] req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_code,
    output logic [(1<<W)-1:0] pend,
    output logic              busy
);
    import prio_enc_pkg::state_t;
    import prio_enc_pkg::IDLE;
    import prio_enc_pkg::HOLD;

    localparam int N = 1 << W;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] pend_next;
    logic [N-1:0] clear_mask;
    logic [N-1:0] find_vec;
    logic [W-1:0] find_start;
    logic [W-1:0] find_idx;
    logic         find_found;
    logic [W-1:0] winner;
    logic         handshake;
    logic         load;

    prio_find #(.W(W)) u_find (
        .vec   (find_vec),
        .start (find_start),
        .idx   (find_idx),
        .found (find_found)
    );

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] last_served;

    // Search upward from the slot after the last one served.
    always_comb begin
        find_vec   = pend;
        find_start = last_served + W'(1);
        winner     = find_idx;
    end

    // Remember the most recently loaded index for the next search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= '0;
        end else if (load) begin
            last_served <= winner;
        end
    end
`else
    // Fixed priority: search the bit-reversed vector from 0, so the first
    // hit is the highest pending index.
    always_comb begin
        find_start = '0;
        find_vec   = '0;
        for (int i = 0; i < N; i++) begin
            find_vec[i] = pend[N-1-i];
        end
        winner = W'(N-1) - find_idx;
    end
`endif

    assign handshake = out_valid & out_ready;
    assign load      = find_found & ((state == IDLE) | handshake);
    assign out_valid = (state == HOLD);
    assign busy      = out_valid | (|pend);

    // Next state and pending update; a new request overrides a clear on the
    // same bit so a re-request is never lost.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        clear_mask = '0;
        if (load) begin
            clear_mask = N'(1) << winner;
        end
        case (state)
            IDLE:    if (find_found) state_next = HOLD;
            HOLD:    if (handshake && !find_found) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        pend_next = (pend & ~clear_mask) | (en ? req : '0);
    end

    // State, pending and output-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            out_code <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            if (load) begin
                out_code <= winner;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_8x3_hs.sv
// Self-checking bench for prio_encoder_8x3_hs: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
// Follows PRIO_ENC_ROUND_ROBIN_EN the same way the design does.
module tb_prio_encoder_8x3_hs;

    localparam int W = 3;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_code;
    logic [N-1:0] pend;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [N-1:0] m_pend;
    logic         m_valid;
    logic [W-1:0] m_code;
    int           m_last;

    prio_encoder_8x3_hs #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pend      (pend),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner choice straight from the priority rule.
    function automatic int pick(input logic [N-1:0] p, input int last);
        int i;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (p[i]) return i;
        end
`else
        for (i = N - 1; i >= 0; i--) begin
            if (p[i] && last >= 0) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = '0;
        m_last  = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        logic         hs;
        logic [N-1:0] clr;
        int           w;
        hs  = m_valid && out_ready;
        clr = '0;
        if ((!m_valid || hs) && m_pend != 0) begin
            w       = pick(m_pend, m_last);
            clr[w]  = 1'b1;
            m_code  = W'(w);
            m_last  = w;
            m_valid = 1'b1;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        m_pend = (m_pend & ~clr) | (en ? req : '0);
    endtask

    task automatic compare_all();
        check("valid", 32'(out_valid), 32'(m_valid));
        check("pend", 32'(pend), 32'(m_pend));
        check("busy", 32'(busy), 32'(m_valid || m_pend != 0));
        if (m_valid) check("code", 32'(out_code), 32'(m_code));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pend"}, 32'(pend), 32'd0);
        check({tag, "_code"}, 32'(out_code), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    logic [W-1:0] codes[$];

    initial begin
        rst_n     = 1'b1;
        en        = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        model_reset();

        // Power-on reset.
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request: code 2 appears for one cycle, then idle.
        en = 1'b1; out_ready = 1'b1; req = 8'b0000_0100;
        cycle();
        req = '0;
        cycle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_code", 32'(out_code), 32'd2);
        cycle();
        check("single_busy", 32'(busy), 32'd0);

        // Burst: served back-to-back in priority order.
        req = 8'b1010_0001;
        cycle();
        req = '0;
        cycle();
`ifndef PRIO_ENC_ROUND_ROBIN_EN
        check("burst_7", 32'(out_code), 32'd7);
        cycle(); check("burst_5", 32'(out_code), 32'd5);
        cycle(); check("burst_0", 32'(out_code), 32'd0);
`else
        cycle(); cycle();
`endif
        cycle();
        check("burst_done", 32'(out_valid), 32'd0);

        // Backpressure: code held stable while out_ready is low.
        out_ready = 1'b0; req = 8'b0001_0010;
        cycle();
        req = '0;
        cycle();
        repeat (4) begin
            cycle();
            check("bp_valid", 32'(out_valid), 32'd1);
        end
`ifndef PRIO_ENC_ROUND_ROBIN_EN
        check("bp_code", 32'(out_code), 32'd4);
        check("bp_pend", 32'(pend), 32'h02);
`endif
        out_ready = 1'b1;
        cycle();
        cycle();
        check("bp_done", 32'(out_valid), 32'd0);

        // Re-request on the bit being loaded: set wins over clear.
        req = 8'b0000_1000;
        cycle();
        cycle();
        check("swc_code", 32'(out_code), 32'd3);
        check("swc_pend", 32'(pend), 32'h08);
        req = '0;
        cycle();
        check("swc_again", 32'(out_code), 32'd3);
        check("swc_valid", 32'(out_valid), 32'd1);
        cycle();

        // Capture disabled: nothing is recorded.
        en = 1'b0; req = 8'hFF;
        repeat (3) begin
            cycle();
            check("en_gate_pend", 32'(pend), 32'd0);
        end
        check("en_gate_valid", 32'(out_valid), 32'd0);

        // Async reset while an index is stalled on the port.
        en = 1'b1; out_ready = 1'b0;
        cycle();
        req = '0;
        cycle();
        check("mid_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two requests held high: rotating or fixed winner sequence.
        out_ready = 1'b1; req = 8'b1000_0001;
        repeat (8) begin
            cycle();
            if (out_valid) codes.push_back(out_code);
        end
        for (int i = 1; i < codes.size(); i++) begin
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            check("rr_alternate", 32'(codes[i] ^ codes[i-1]), 32'd7);
`else
            check("fixed_repeat", 32'(codes[i]), 32'd7);
`endif
        end
        req = '0;
        repeat (10) cycle();
        check("drain_busy", 32'(busy), 32'd0);

        // Randomized traffic against the model.
        repeat (400) begin
            en        = ($urandom_range(0, 3) != 0);
            req       = N'($urandom & $urandom & $urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
